// File: rtl/wm8731_pkg.sv
// rtl/wm8731_pkg.sv - shared types and constants for the WM8731 init sequencer
package wm8731_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_REQ,
    S_WAIT_DONE,
    S_SETTLE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int NUM_REGS = 11;

  localparam logic [6:0] R0  = 7'h00;
  localparam logic [6:0] R1  = 7'h01;
  localparam logic [6:0] R2  = 7'h02;
  localparam logic [6:0] R3  = 7'h03;
  localparam logic [6:0] R4  = 7'h04;
  localparam logic [6:0] R5  = 7'h05;
  localparam logic [6:0] R6  = 7'h06;
  localparam logic [6:0] R7  = 7'h07;
  localparam logic [6:0] R8  = 7'h08;
  localparam logic [6:0] R9  = 7'h09;
  localparam logic [6:0] R15 = 7'h0F;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } cfg_entry_t;

endpackage

// File: rtl/wm8731_cfg_rom.sv
// rtl/wm8731_cfg_rom.sv - power-up register table, index to {reg, data}
module wm8731_cfg_rom
  import wm8731_pkg::*;
(
  input  logic [3:0] index,
  output cfg_entry_t entry
);

  always_comb begin
    entry = '0;
    case (index)
      4'd0:    entry = '{R15, 9'h000};
      4'd1:    entry = '{R0,  9'h017};
      4'd2:    entry = '{R1,  9'h017};
      4'd3:    entry = '{R2,  9'h079};
      4'd4:    entry = '{R3,  9'h079};
      4'd5:    entry = '{R4,  9'h012};
      4'd6:    entry = '{R5,  9'h000};
      4'd7:    entry = '{R6,  9'h000};
      4'd8:    entry = '{R7,  9'h002};
      4'd9:    entry = '{R8,  9'h000};
      4'd10:   entry = '{R9,  9'h001};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/wm8731_init_seq.sv
// rtl/wm8731_init_seq.sv - walks the codec register table through the I2C byte-writer
module wm8731_init_seq
  import wm8731_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR      = 8'h34,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        i2c_req,
  output logic [23:0] i2c_word,
  input  logic        i2c_ack,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  err_index
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t       state, state_next;
  logic [3:0]   index;
  logic [RW-1:0] retry;
  logic [SW-1:0] settle_cnt;
  logic         last_ok;
  cfg_entry_t   entry;
  logic         last_index;
  logic         retry_left;

  wm8731_cfg_rom u_rom (
    .index (index),
    .entry (entry)
  );

  assign last_index = (index == 4'(NUM_REGS - 1));
  assign retry_left = (retry < RW'(MAX_RETRY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LOAD;
      S_LOAD:                  state_next = S_REQ;
      S_REQ:                   if (i2c_ack) state_next = S_WAIT_DONE;
      S_WAIT_DONE:
        if (i2c_done) state_next = (!i2c_nack || retry_left) ? S_SETTLE : S_ERROR;
      S_SETTLE:
        if (settle_cnt == '0) state_next = (last_ok && last_index) ? S_DONE : S_LOAD;
      default:                 state_next = S_IDLE;
    endcase
  end

  always_comb begin
    i2c_req = (state == S_REQ);
    busy    = (state == S_LOAD) || (state == S_REQ) ||
              (state == S_WAIT_DONE) || (state == S_SETTLE);
  end

  // A NACKed write keeps the index so the same entry is resent after the settle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i2c_word   <= '0;
      index      <= '0;
      retry      <= '0;
      settle_cnt <= '0;
      last_ok    <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_index  <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            done  <= 1'b0;
            error <= 1'b0;
            index <= '0;
            retry <= '0;
          end
        end
        S_LOAD: i2c_word <= {DEV_ADDR, entry};
        S_WAIT_DONE: begin
          if (i2c_done) begin
            settle_cnt <= SW'(SETTLE_CYCLES - 1);
            last_ok    <= !i2c_nack;
            if (!i2c_nack) begin
              retry <= '0;
            end else if (retry_left) begin
              retry <= retry + RW'(1);
            end else begin
              error     <= 1'b1;
              err_index <= index;
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            if (last_ok) begin
              if (last_index) done <= 1'b1;
              else            index <= index + 4'd1;
            end
          end else begin
            settle_cnt <= settle_cnt - SW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wm8731_init_seq.sv
// tb/tb_wm8731_init_seq.sv - scoreboard bench for the WM8731 init sequencer
module tb_wm8731_init_seq;

  localparam int SC = 4;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        t_start = 1'b0, nz_start = 1'b0;
  logic        i2c_ack = 1'b0;
  logic        s_done = 1'b0, t_done = 1'b0, s_nack = 1'b0, t_nack = 1'b0;
  logic        start, i2c_done, i2c_nack;
  logic        i2c_req, busy, done, error;
  logic [23:0] i2c_word;
  logic [3:0]  err_index;

  assign start    = t_start | nz_start;
  assign i2c_done = s_done | t_done;
  assign i2c_nack = s_nack | t_nack;

  int total = 0, bad = 0, cyc = 0;
  logic [23:0] tbl [11] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679,
                            24'h340812, 24'h340A00, 24'h340C00, 24'h340E02, 24'h341000,
                            24'h341201};
  logic [23:0] exp_q [$];
  int nack_plan [11];
  int attempts [11];
  int ack_lo = 0, ack_hi = 4, dn_lo = 1, dn_hi = 12;
  int hold_idx = -1, last_done_cyc = 0, exp_err_idx = 0;
  bit held = 0, have_done = 0, nz_en = 0, exp_err = 0;

  logic [23:0] sw;
  int sd, sdd, six;
  bit sok;

  wm8731_init_seq #(.DEV_ADDR(8'h34), .SETTLE_CYCLES(SC), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .start(start), .i2c_req(i2c_req), .i2c_word(i2c_word),
    .i2c_ack(i2c_ack), .i2c_done(i2c_done), .i2c_nack(i2c_nack), .busy(busy),
    .done(done), .error(error), .err_index(err_index)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [23:0] w);
    for (int i = 0; i < 11; i++) if (tbl[i] == w) return i;
    return -1;
  endfunction

  // I2C master model: ack after a delay, then done with a planned NACK decision.
  initial forever begin
    @(negedge clk);
    if (i2c_req === 1'b1) begin
      sw  = i2c_word;
      six = idx_of(sw);
      if (have_done) chk("settle_gap", cyc - last_done_cyc, SC + 2);
      have_done = 0;
      sd  = $urandom_range(ack_hi, ack_lo);
      sok = 1;
      repeat (sd) begin
        @(negedge clk);
        if (i2c_req !== 1'b1 || i2c_word !== sw) sok = 0;
      end
      if (sd > 0) chk("req_stable", 32'(sok), 1);
      i2c_ack = 1'b1;
      if ($urandom_range(3, 0) == 0) begin
        s_done = 1'b1;
        s_nack = 1'b1;
      end
      @(negedge clk);
      i2c_ack = 1'b0;
      s_done  = 1'b0;
      s_nack  = 1'b0;
      chk("req_drop", 32'(i2c_req), 0);
      if (six == hold_idx) begin
        held = 1;
      end else begin
        sdd = $urandom_range(dn_hi, dn_lo);
        repeat (sdd - 1) @(negedge clk);
        s_done = 1'b1;
        s_nack = (six >= 0) && (attempts[six] < nack_plan[six]);
        if (six >= 0) attempts[six]++;
        last_done_cyc = cyc;
        have_done = 1;
        @(negedge clk);
        s_done = 1'b0;
        s_nack = 1'b0;
      end
    end
  end

  // Scoreboard monitor: every accepted write is checked against the expected queue.
  initial forever begin
    @(negedge clk);
    #1;
    if (i2c_req === 1'b1 && i2c_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write actual=%h expected=none", i2c_word);
      end else begin
        chk("write_word", i2c_word, exp_q.pop_front());
      end
    end
  end

  // Stray start pulses while busy must never restart the sequence.
  initial forever begin
    @(negedge clk);
    if (nz_en && busy === 1'b1 && $urandom_range(15, 0) == 0) begin
      nz_start = 1'b1;
      @(negedge clk);
      nz_start = 1'b0;
    end
  end

  task automatic begin_run();
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < 11; i++) begin
      if (nack_plan[i] > MR) begin
        repeat (MR + 1) exp_q.push_back(tbl[i]);
        exp_err = 1;
        exp_err_idx = i;
        break;
      end
      repeat (nack_plan[i] + 1) exp_q.push_back(tbl[i]);
    end
    for (int i = 0; i < 11; i++) attempts[i] = 0;
    have_done = 0;
    held = 0;
    @(negedge clk);
    t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    chk("busy_n1", 32'(busy), 1);
    chk("req_n1", 32'(i2c_req), 0);
    chk("flags_clr", {30'b0, done, error}, 0);
    @(negedge clk);
    chk("req_n2", 32'(i2c_req), 1);
    chk("word_n2", i2c_word, tbl[0]);
  endtask

  task automatic finish_run();
    int n = 0;
    bit quiet = 1;
    while (!(done === 1'b1 || error === 1'b1) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      total++;
      bad++;
      $display("FAIL run_timeout actual=busy expected=done_or_error");
    end else begin
      if (exp_err) chk("err_timing", cyc - last_done_cyc, 1);
      else         chk("done_timing", cyc - last_done_cyc, SC + 1);
      chk("done_flag", 32'(done), 32'(!exp_err));
      chk("error_flag", 32'(error), 32'(exp_err));
      chk("busy_end", 32'(busy), 0);
      if (exp_err) chk("err_index", 32'(err_index), exp_err_idx);
      chk("queue_empty", exp_q.size(), 0);
    end
    repeat (10) begin
      @(negedge clk);
      if (i2c_req !== 1'b0 || busy !== 1'b0) quiet = 0;
    end
    chk("quiet_after", 32'(quiet), 1);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < 11; i++) nack_plan[i] = 0;
  endtask

  initial begin
    int n;
    bit ok;
    clear_plan();
    repeat (3) @(negedge clk);
    chk("reset_outs", {i2c_req, busy, done, error, err_index, i2c_word}, 0);
    reset = 1'b0;
    nz_en = 1;

    // Normal run with fixed handshake timing.
    ack_lo = 2; ack_hi = 2; dn_lo = 10; dn_hi = 10;
    begin_run(); finish_run();

    ack_lo = 0; ack_hi = 4; dn_lo = 1; dn_hi = 12;
    nack_plan[3] = 1;
    begin_run(); finish_run();

    clear_plan(); nack_plan[5] = 99;
    begin_run(); finish_run();

    // Restart directly from ERROR.
    clear_plan();
    begin_run(); finish_run();

    ack_lo = 50; ack_hi = 50;
    begin_run(); finish_run();
    ack_lo = 0; ack_hi = 4;

    // Reset while waiting for the transfer at index 6, then a late done.
    nz_en = 0;
    hold_idx = 6;
    begin_run();
    n = 0;
    while (!held && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++;
      bad++;
      $display("FAIL hold_timeout actual=no_write expected=index6");
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_mid_outs", {i2c_req, busy, done, error, err_index, i2c_word}, 0);
    @(negedge clk);
    reset = 1'b0;
    hold_idx = -1;
    exp_q.delete();
    have_done = 0;
    repeat (2) @(negedge clk);
    t_done = 1'b1;
    @(negedge clk);
    t_done = 1'b0;
    ok = 1;
    repeat (8) begin
      @(negedge clk);
      if (busy !== 1'b0 || i2c_req !== 1'b0) ok = 0;
    end
    chk("idle_after_late_done", 32'(ok), 1);
    begin_run(); finish_run();
    nz_en = 1;

    // Randomized NACK placements and counts.
    for (int r = 0; r < 6; r++) begin
      clear_plan();
      nack_plan[$urandom_range(10, 0)] = $urandom_range(4, 0);
      begin_run(); finish_run();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
